// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//   Feeds one flattened pixel window into the multiply_accumulate stage, one
//   pixel/coefficient pair per cycle. It then captures the MAC result, shifts it
//   right and saturates it to pixel width, and hands one output pixel per window
//   downstream.
//
// Ports
//   clk, aresetn              clock, asynchronous active-low reset
//   coef_we/addr/wdata        coefficient bank write (taken only while idle)
//   win_valid/ready/data      window input handshake; tap i at [i*DATA_W +: DATA_W]
//   mac_reset, mac_en         MAC accumulator clear / accumulate strobes
//   mac_data, mac_multi       MAC operands (pixel, coefficient)
//   mac_result, mac_overflow  MAC accumulator value and overflow flag
//   pix_valid/ready/data      output pixel handshake
//   pix_sat                   pix_data was saturated (qualified by pix_valid)
//
// state | meaning
// IDLE  | ready for a window; coefficient writes accepted
// CLEAR | one-cycle mac_reset pulse
// FEED  | KERNEL_LEN cycles of mac_en, one tap per cycle
// DRAIN | MAC_LAT cycles waiting for the MAC; result captured on the last one
// OUT   | pixel presented until pix_ready
module conv_window_sequencer #(
  parameter int DATA_W     = 4,
  parameter int RESULT_W   = 16,
  parameter int KERNEL_LEN = 8,
  parameter int MAC_LAT    = 1,
  parameter int SHIFT      = 3
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic                             coef_we,
  input  logic [$clog2(KERNEL_LEN)-1:0]    coef_addr,
  input  logic [DATA_W-1:0]                coef_wdata,
  input  logic                             win_valid,
  output logic                             win_ready,
  input  logic [KERNEL_LEN*DATA_W-1:0]     win_data,
  output logic                             mac_reset,
  output logic                             mac_en,
  output logic [DATA_W-1:0]                mac_data,
  output logic [DATA_W-1:0]                mac_multi,
  input  logic [RESULT_W-1:0]              mac_result,
  input  logic                             mac_overflow,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [DATA_W-1:0]                pix_data,
  output logic                             pix_sat
);

  localparam int IDX_W = $clog2(KERNEL_LEN);
  localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(KERNEL_LEN - 1);
  localparam logic [CNT_W-1:0]    LAT_INIT = CNT_W'(MAC_LAT - 1);
  localparam logic [RESULT_W-1:0] PIX_MAX  = RESULT_W'((1 << DATA_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_OUT
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   coef_q [KERNEL_LEN];
  logic [DATA_W-1:0]   tap_q  [KERNEL_LEN];
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    lat_cnt_q;
  logic [DATA_W-1:0]   pix_data_q;
  logic                pix_sat_q;

  logic [RESULT_W-1:0] shifted;
  logic                norm_sat;
  logic [DATA_W-1:0]   norm_data;

  assign shifted   = mac_result >> SHIFT;
  assign norm_sat  = mac_overflow || (shifted > PIX_MAX);
  assign norm_data = norm_sat ? '1 : shifted[DATA_W-1:0];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_ready = 1'b0;
    pix_valid = 1'b0;
    mac_reset = 1'b0;
    mac_en    = 1'b0;
    mac_data  = '0;
    mac_multi = '0;
    case (state_q)
      S_IDLE: begin
        win_ready = 1'b1;
        if (win_valid) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        mac_reset = 1'b1;
        state_d   = S_FEED;
      end
      S_FEED: begin
        mac_en    = 1'b1;
        mac_data  = tap_q[idx_q];
        mac_multi = coef_q[idx_q];
        if (idx_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (lat_cnt_q == '0) state_d = S_OUT;
      end
      S_OUT: begin
        pix_valid = 1'b1;
        if (pix_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Coefficient bank and window latch; both only move while idle, so a write
  // in the accepting cycle lands before the first FEED read.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < KERNEL_LEN; i++) begin
        coef_q[i] <= '0;
        tap_q[i]  <= '0;
      end
    end else if (state_q == S_IDLE) begin
      if (coef_we && (32'(coef_addr) < KERNEL_LEN)) coef_q[coef_addr] <= coef_wdata;
      if (win_valid) begin
        for (int i = 0; i < KERNEL_LEN; i++) tap_q[i] <= win_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tap index (up) and MAC latency timer (down-counter, terminal count 0).
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      idx_q     <= '0;
      lat_cnt_q <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          idx_q     <= '0;
          lat_cnt_q <= LAT_INIT;
        end
        S_FEED: idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        S_DRAIN: if (lat_cnt_q != '0) lat_cnt_q <= lat_cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Result is normalised at capture, so pix_data/pix_sat stay frozen in OUT.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pix_data_q <= '0;
      pix_sat_q  <= 1'b0;
    end else if ((state_q == S_DRAIN) && (lat_cnt_q == '0)) begin
      pix_data_q <= norm_data;
      pix_sat_q  <= norm_sat;
    end
  end

  assign pix_data = pix_data_q;
  assign pix_sat  = pix_sat_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Testbench for conv_window_sequencer: a MAC_LAT=1 instance carries the main
// directed and random traffic; a MAC_LAT=3 instance checks the longer drain.
module tb_conv_window_sequencer;

  localparam int DW = 4;
  localparam int RW = 16;
  localparam int KL = 8;
  localparam int SH = 3;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic          coef_we = 1'b0;
  logic [2:0]    coef_addr = '0;
  logic [DW-1:0] coef_wdata = '0;
  logic [KL*DW-1:0] win_data = '0;
  logic          pix_ready = 1'b0;
  logic          force_ovf = 1'b0;

  logic win_valid1 = 1'b0, win_ready1, mac_reset1, mac_en1, mac_overflow1, pix_valid1, pix_sat1;
  logic [DW-1:0] mac_data1, mac_multi1, pix_data1;
  logic [RW-1:0] mac_result1;

  logic win_valid3 = 1'b0, win_ready3, mac_reset3, mac_en3, mac_overflow3, pix_valid3, pix_sat3;
  logic [DW-1:0] mac_data3, mac_multi3, pix_data3;
  logic [RW-1:0] mac_result3;

  conv_window_sequencer #(.DATA_W(DW), .RESULT_W(RW), .KERNEL_LEN(KL), .MAC_LAT(1), .SHIFT(SH)) u_dut1 (
    .clk(clk), .aresetn(aresetn),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .win_valid(win_valid1), .win_ready(win_ready1), .win_data(win_data),
    .mac_reset(mac_reset1), .mac_en(mac_en1), .mac_data(mac_data1), .mac_multi(mac_multi1),
    .mac_result(mac_result1), .mac_overflow(mac_overflow1),
    .pix_valid(pix_valid1), .pix_ready(pix_ready), .pix_data(pix_data1), .pix_sat(pix_sat1)
  );

  conv_window_sequencer #(.DATA_W(DW), .RESULT_W(RW), .KERNEL_LEN(KL), .MAC_LAT(3), .SHIFT(SH)) u_dut3 (
    .clk(clk), .aresetn(aresetn),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .win_valid(win_valid3), .win_ready(win_ready3), .win_data(win_data),
    .mac_reset(mac_reset3), .mac_en(mac_en3), .mac_data(mac_data3), .mac_multi(mac_multi3),
    .mac_result(mac_result3), .mac_overflow(mac_overflow3),
    .pix_valid(pix_valid3), .pix_ready(pix_ready), .pix_data(pix_data3), .pix_sat(pix_sat3)
  );

  // Behavioural MACs: latency 1 shows the accumulator directly, latency 3
  // adds two pipeline stages so an early capture sees a partial sum.
  logic [RW-1:0] acc1, acc3, d3a, d3b;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc1 <= '0; acc3 <= '0; d3a <= '0; d3b <= '0;
    end else begin
      if (mac_reset1) acc1 <= '0;
      else if (mac_en1) acc1 <= acc1 + ({12'b0, mac_data1} * {12'b0, mac_multi1});
      if (mac_reset3) acc3 <= '0;
      else if (mac_en3) acc3 <= acc3 + ({12'b0, mac_data3} * {12'b0, mac_multi3});
      d3a <= acc3;
      d3b <= d3a;
    end
  end
  assign mac_result1   = acc1;
  assign mac_overflow1 = force_ovf;
  assign mac_result3   = d3b;
  assign mac_overflow3 = 1'b0;

  // Monitor of the MAC-side traffic of the latency-1 instance.
  logic          mon_clr = 1'b1;
  int            en_cnt, rst_cnt, idle_nz;
  logic          order_bad;
  logic [DW-1:0] seen_d [KL];
  logic [DW-1:0] seen_m [KL];
  always @(posedge clk) begin
    if (mon_clr) begin
      en_cnt <= 0; rst_cnt <= 0; idle_nz <= 0; order_bad <= 1'b0;
    end else begin
      if (mac_reset1) rst_cnt <= rst_cnt + 1;
      if (mac_en1) begin
        if (en_cnt < KL) begin
          seen_d[en_cnt] <= mac_data1;
          seen_m[en_cnt] <= mac_multi1;
        end
        en_cnt <= en_cnt + 1;
        if (rst_cnt == 0) order_bad <= 1'b1;
      end else if (mac_data1 != '0 || mac_multi1 != '0) begin
        idle_nz <= idle_nz + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mcoef [KL];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = 3'(a); coef_wdata = DW'(v);
    tick();
    coef_we = 1'b0;
    mcoef[a] = DW'(v);
  endtask

  function automatic int dot(input logic [31:0] taps);
    int s = 0;
    for (int i = 0; i < KL; i++) s += int'(taps[i*DW +: DW]) * int'(mcoef[i]);
    return s;
  endfunction

  // One window through the latency-1 instance, checked end to end.
  task automatic run_window(input logic [31:0] taps, input int stall, input bit cw_en,
                            input int cw_a, input int cw_v, input int feed_wr, input bit ovf);
    int sum, s, exp_d, exp_s, cyc;
    logic [31:0] od, om, pc;
    force_ovf  = ovf;
    win_data   = taps;
    win_valid1 = 1'b1;
    mon_clr    = 1'b1;
    pix_ready  = (stall == 0);
    if (cw_en) begin
      coef_we = 1'b1; coef_addr = 3'(cw_a); coef_wdata = DW'(cw_v);
    end
    cyc = 0;
    while (!win_ready1 && cyc < 40) begin tick(); cyc++; end
    check("accept_wait", 32'(cyc < 40), 32'd1);
    if (cw_en) mcoef[cw_a] = DW'(cw_v);
    for (int i = 0; i < KL; i++) pc[i*DW +: DW] = mcoef[i];
    sum   = dot(taps);
    s     = sum >> SH;
    exp_s = (ovf || s > 15) ? 1 : 0;
    exp_d = exp_s ? 15 : s;
    tick();
    win_valid1 = 1'b0; coef_we = 1'b0; mon_clr = 1'b0;
    cyc = 1;
    while (!pix_valid1 && cyc < 40) begin
      if (cyc == feed_wr) begin
        coef_we = 1'b1; coef_addr = 3'd3; coef_wdata = 4'd9;
      end else begin
        coef_we = 1'b0;
      end
      tick();
      cyc++;
    end
    coef_we = 1'b0;
    check("latency", 32'(cyc), 32'(KL + 1 + 2));
    check("mac_reset_cycles", 32'(rst_cnt), 32'd1);
    check("mac_en_cycles", 32'(en_cnt), 32'(KL));
    check("reset_before_en", 32'(order_bad), 32'd0);
    check("operands_zero_outside_feed", 32'(idle_nz), 32'd0);
    for (int i = 0; i < KL; i++) begin
      od[i*DW +: DW] = seen_d[i];
      om[i*DW +: DW] = seen_m[i];
    end
    check("mac_data_seq", od, taps);
    check("mac_multi_seq", om, pc);
    check("pix_data", 32'(pix_data1), 32'(exp_d));
    check("pix_sat", 32'(pix_sat1), 32'(exp_s));
    for (int k = 0; k < stall; k++) begin
      win_valid1 = 1'b1;
      tick();
      check("hold_valid", 32'(pix_valid1), 32'd1);
      check("hold_data", 32'(pix_data1), 32'(exp_d));
      check("hold_sat", 32'(pix_sat1), 32'(exp_s));
      check("hold_win_ready", 32'(win_ready1), 32'd0);
    end
    win_valid1 = 1'b0;
    pix_ready  = 1'b1;
    tick();
    pix_ready  = 1'b0;
    check("post_handshake_valid", 32'(pix_valid1), 32'd0);
    check("post_handshake_ready", 32'(win_ready1), 32'd1);
    force_ovf = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit stale;
    logic [31:0] taps;
    for (int i = 0; i < KL; i++) mcoef[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_win_ready", 32'(win_ready1), 32'd1);
    check("rst_pix_valid", 32'(pix_valid1), 32'd0);
    check("rst_pix_data", 32'(pix_data1), 32'd0);
    check("rst_pix_sat", 32'(pix_sat1), 32'd0);
    check("rst_mac_ctl", {30'd0, mac_reset1, mac_en1}, 32'd0);
    check("rst_mac_ops", {24'd0, mac_data1, mac_multi1}, 32'd0);
    aresetn = 1'b1;
    tick();

    // Ramp window against unit coefficients: 36 >> 3 = 4.
    for (int i = 0; i < KL; i++) write_coef(i, 1);
    run_window(32'h87654321, 0, 0, 0, 0, -1, 0);
    // Full-scale: 1800 >> 3 = 225 saturates.
    for (int i = 0; i < KL; i++) write_coef(i, 15);
    run_window(32'hFFFFFFFF, 0, 0, 0, 0, -1, 0);
    // Overflow flag forces saturation on an otherwise small result.
    for (int i = 0; i < KL; i++) write_coef(i, 1);
    run_window(32'h11111111, 0, 0, 0, 0, -1, 1);
    // Downstream back-pressure for 5 cycles.
    run_window(32'h87654321, 5, 0, 0, 0, -1, 0);
    // Write during FEED is dropped, then same write in the accepting cycle is used.
    run_window(32'h11111111, 0, 0, 0, 0, 4, 0);
    run_window(32'h11111111, 0, 0, 0, 0, -1, 0);
    run_window(32'h11111111, 0, 1, 3, 9, -1, 0);

    // Asynchronous reset while feeding tap index 4.
    win_data = 32'h87654321;
    win_valid1 = 1'b1;
    tick();
    win_valid1 = 1'b0;
    repeat (5) tick();
    check("pre_reset_feed", {27'd0, mac_en1, mac_data1}, {27'd0, 1'b1, 4'd5});
    aresetn = 1'b0;
    #1;
    check("arst_win_ready", 32'(win_ready1), 32'd1);
    check("arst_pix", {30'd0, pix_valid1, pix_sat1}, 32'd0);
    check("arst_pix_data", 32'(pix_data1), 32'd0);
    check("arst_mac_ctl", {30'd0, mac_reset1, mac_en1}, 32'd0);
    check("arst_mac_ops", {24'd0, mac_data1, mac_multi1}, 32'd0);
    check("arst_dut3", {30'd0, win_ready3, pix_valid3}, 32'd2);
    for (int i = 0; i < KL; i++) mcoef[i] = '0;
    #3;
    aresetn = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (pix_valid1) stale = 1'b1;
    end
    check("no_stale_pixel", 32'(stale), 32'd0);
    run_window(32'h11111111, 0, 0, 0, 0, -1, 0);

    // Random traffic against the arithmetic model.
    for (int n = 0; n < 20; n++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) write_coef(int'($urandom_range(0, KL - 1)), int'($urandom_range(0, 15)));
      taps = $urandom;
      run_window(taps, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, KL - 1)), int'($urandom_range(0, 15)),
                 -1, ($urandom_range(0, 7) == 0));
    end

    // Latency-3 instance: coefs 2, ramp taps -> 72 >> 3 = 9 (partial sum gives 7).
    for (int i = 0; i < KL; i++) write_coef(i, 2);
    win_data   = 32'h87654321;
    pix_ready  = 1'b1;
    win_valid3 = 1'b1;
    cyc = 0;
    while (!win_ready3 && cyc < 40) begin tick(); cyc++; end
    check("lat3_accept_wait", 32'(cyc < 40), 32'd1);
    tick();
    win_valid3 = 1'b0;
    cyc = 1;
    while (!pix_valid3 && cyc < 40) begin tick(); cyc++; end
    check("lat3_latency", 32'(cyc), 32'(KL + 3 + 2));
    check("lat3_pix_data", 32'(pix_data3), 32'd9);
    check("lat3_pix_sat", 32'(pix_sat3), 32'd0);
    tick();
    check("lat3_post_handshake", {30'd0, pix_valid3, win_ready3}, 32'd1);
    pix_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Upstream feeder for the multiply_accumulate stage in the image-convolution datapath.
- Accepts one flattened pixel window per handshake and streams KERNEL_LEN pixel/coefficient pairs into the MAC, one pair per cycle.
- Captures the MAC result, normalises it by a right shift with saturation to pixel width, and presents one output pixel per window downstream over valid/ready.

Parameters:
- DATA_W, 4, pixel and coefficient width (unsigned); must match MAC I_OPP_W.
- RESULT_W, 16, MAC accumulator width; must match MAC O_OPP_W.
- KERNEL_LEN, 8, taps per window (>=2).
- MAC_LAT, 1, cycles from the last mac_en cycle until mac_result is final (>=1).
- SHIFT, 3, normalisation right shift applied to the MAC result.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(KERNEL_LEN)  coefficient index.
- coef_wdata  in  DATA_W  coefficient value.
- win_valid  in  1  window available.
- win_ready  out  1  sequencer can accept a window.
- win_data  in  KERNEL_LEN*DATA_W  window; tap i is at bits [i*DATA_W +: DATA_W].
- mac_reset  out  1  clears the MAC accumulator.
- mac_en  out  1  MAC accumulates mac_data*mac_multi this cycle.
- mac_data  out  DATA_W  pixel operand.
- mac_multi  out  DATA_W  coefficient operand.
- mac_result  in  RESULT_W  MAC accumulator value.
- mac_overflow  in  1  MAC overflow flag.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accepts the pixel.
- pix_data  out  DATA_W  normalised pixel.
- pix_sat  out  1  pix_data was saturated; qualified by pix_valid.

Behaviour:
- Reset (async, any state):
  - state=IDLE; coefficient bank cleared to 0; tap index=0.
  - win_ready=1, pix_valid=0, pix_data=0, pix_sat=0.
  - mac_reset=0, mac_en=0, mac_data=0, mac_multi=0.
  - Reset mid-window discards the window with no output.
- Coefficient writes are accepted only in IDLE; coef_we in any other state is ignored. A write and a window handshake in the same IDLE cycle are both accepted, and the written value is used for that window.
- FSM states: IDLE, CLEAR, FEED, DRAIN, OUT.
- IDLE:
  - win_ready=1.
  - On win_valid&&win_ready, latch win_data and go to CLEAR.
  - win_ready is 0 in every other state.
- CLEAR: mac_reset=1 for exactly one cycle; index=0; then FEED.
- FEED:
  - mac_en=1, mac_data=tap[index], mac_multi=coef[index].
  - index increments each cycle; after index==KERNEL_LEN-1, go to DRAIN.
  - Lasts exactly KERNEL_LEN cycles.
- DRAIN:
  - mac_en=0; wait MAC_LAT cycles.
  - On the last DRAIN cycle, register mac_result and mac_overflow, then go to OUT.
- OUT:
  - pix_valid=1. pix_data and pix_sat are held stable until pix_ready.
  - On pix_valid&&pix_ready, go to IDLE.
  - A new window is not accepted in the handshake cycle, so the minimum gap between acceptances is KERNEL_LEN+MAC_LAT+3 cycles.
- Latency: with cycle 1 being the first cycle after the accepting edge, CLEAR occupies cycle 1, FEED cycles 2..KERNEL_LEN+1, DRAIN the next MAC_LAT cycles, and pix_valid rises in cycle KERNEL_LEN+MAC_LAT+2.
- Normalisation:
  - s = mac_result >> SHIFT (logical).
  - If mac_overflow=1 or s > 2^DATA_W-1: pix_data = all ones, pix_sat=1.
  - Otherwise pix_data = s[DATA_W-1:0], pix_sat=0.
- mac_data and mac_multi are 0 outside FEED.
- No combinational path from win_valid or pix_ready to any output other than the handshake itself.

Test Plan:
(Bench uses DATA_W=4, RESULT_W=16, KERNEL_LEN=8, SHIFT=3 and a behavioural MAC model with MAC_LAT=1 unless noted.)
- Coefs all 1, window taps 1..8, pix_ready=1 -> sum 36, pix_data=4, pix_sat=0; pix_valid rises 11 cycles after acceptance; exactly 8 mac_en cycles preceded by one mac_reset cycle.
- Coefs all 15, taps all 15 -> 1800>>3=225 > 15, so pix_data=15, pix_sat=1.
- MAC model forces mac_overflow=1 on a window whose result is 8 -> pix_data=15, pix_sat=1.
- pix_ready held 0 for 5 cycles in OUT -> pix_valid, pix_data and pix_sat stable throughout; win_ready=0 even with win_valid=1; the next window is accepted only after the pixel handshake.
- coef_we to addr 3 during FEED -> ignored, current and next result unchanged; the same write in IDLE -> used by the next window (coefs 1 except coef[3]=9, taps all 1 -> 16>>3=2).
- aresetn pulsed low during FEED (index 4) -> all outputs at reset values immediately; coefs read back as 0; the next window (taps all 1) yields pix_data=0; no stale pixel is emitted.
- MAC_LAT=3 build -> pix_valid rises 13 cycles after acceptance; result captured on the third DRAIN cycle.
